// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: access sizes, IO segment
// decode, FSM state type and small load/size helpers.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // addr[17:16] of the UART/IO segment; writes here honour io_buffer_full
  localparam logic [1:0] IO_SEG = 2'b11;

  // only this many low address bits reach memory decode
  localparam int MEM_AW = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // index of the final byte of an access; the unused code 3 behaves as a word
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      SZ_B:    last_byte = 2'd0;
      SZ_H:    last_byte = 2'd1;
      default: last_byte = 2'd3;
    endcase
  endfunction

  // zero/sign extension of an assembled load, keyed by its final byte index
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  last,
                                              input logic        sext);
    case (last)
      2'd0:    extend_load = {{24{sext & raw[7]}}, raw[7:0]};
      2'd1:    extend_load = {{16{sext & raw[15]}}, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin request selector. The channel after the most recently
// granted one has top priority; channel 0 leads after reset.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // first requester at or after the pointer, wrapping around
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // move priority past the channel that was just granted
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ID_W'((int'(grant_id) + 1) % NUM_CH);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between NUM_CH requesters. Each granted
// request is split into 1/2/4 little-endian byte beats; loads are assembled
// and extended, stores to the IO segment wait while the UART buffer is full.
//
// state | meaning
// IDLE  | outputs quiet, arbitrating among pending requests
// RD    | issuing read addresses and capturing bytes one cycle later
// WR    | driving store bytes, holding a beat while the IO buffer is full
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     io_buffer_full,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_sext,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        resp_done,
  output logic [31:0]              resp_rdata
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              take;

  logic [ADDR_W-1:0] sel_addr;
  logic [MEM_AW-1:0] sel_a;
  logic [1:0]        sel_size;
  logic              sel_we;
  logic              sel_sext;
  logic [31:0]       sel_wdata;
  logic              unused_addr_hi;

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [MEM_AW-1:0] base;
  logic [31:0]       wbuf;
  logic [31:0]       rbuf;
  logic [31:0]       rd_raw;
  logic [1:0]        last;
  logic              sext_q;
  logic [2:0]        cnt;
  logic              drv;

  logic [1:0]        next_idx;
  logic [MEM_AW-1:0] next_a;
  logic [MEM_AW-1:0] cur_a;
  logic              grant_stall;
  logic              next_stall;
  logic              cur_stall;

  // a grant is only taken from IDLE and never in a flush cycle
  assign take = (state == IDLE) && !clear && (|grant);

  // the channel receiving resp_done this cycle sits out this arbitration
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .req      (req_valid & ~resp_done),
    .advance  (rdy_in && take),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_addr       = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
  assign sel_a          = sel_addr[MEM_AW-1:0];
  assign sel_size       = req_size[int'(grant_id)*2 +: 2];
  assign sel_we         = req_we[grant_id];
  assign sel_sext       = req_sext[grant_id];
  assign sel_wdata      = req_wdata[int'(grant_id)*32 +: 32];
  assign unused_addr_hi = ^sel_addr;

  assign next_idx    = cnt[1:0] + 2'd1;
  assign next_a      = base + MEM_AW'(next_idx);
  assign cur_a       = base + MEM_AW'(cnt[1:0]);
  assign grant_stall = (sel_a[17:16] == IO_SEG) && io_buffer_full;
  assign next_stall  = (next_a[17:16] == IO_SEG) && io_buffer_full;
  assign cur_stall   = (cur_a[17:16] == IO_SEG) && io_buffer_full;

  // final load byte comes straight from mem_din in the completion cycle
  always_comb begin
    rd_raw = rbuf;
    rd_raw[{last, 3'b000} +: 8] = mem_din;
  end

  // access sequencer; all memory-side outputs are registered here
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      owner      <= '0;
      base       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      last       <= '0;
      sext_q     <= 1'b0;
      cnt        <= '0;
      drv        <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      resp_done  <= '0;
      resp_rdata <= '0;
    end else if (!rdy_in) begin
      // frozen: a beat already on the bus counts as done when rdy returns
      mem_wr    <= 1'b0;
      resp_done <= '0;
    end else begin
      resp_done <= '0;
      case (state)
        IDLE: begin
          mem_a    <= '0;
          mem_dout <= '0;
          mem_wr   <= 1'b0;
          drv      <= 1'b0;
          cnt      <= '0;
          if (take) begin
            owner  <= grant_id;
            base   <= sel_a;
            wbuf   <= sel_wdata;
            last   <= last_byte(sel_size);
            sext_q <= sel_sext;
            mem_a  <= 32'(sel_a);
            if (sel_we) begin
              state    <= WR;
              mem_dout <= sel_wdata[7:0];
              mem_wr   <= !grant_stall;
              drv      <= !grant_stall;
            end else begin
              state <= RD;
            end
          end
        end

        RD: begin
          if (clear) begin
            state <= IDLE;
            mem_a <= '0;
            cnt   <= '0;
          end else if (cnt == ({1'b0, last} + 3'd1)) begin
            state            <= IDLE;
            cnt              <= '0;
            mem_a            <= '0;
            resp_done[owner] <= 1'b1;
            resp_rdata       <= extend_load(rd_raw, last, sext_q);
          end else begin
            if (cnt != 3'd0) begin
              rbuf[{cnt[1:0] - 2'd1, 3'b000} +: 8] <= mem_din;
            end
            mem_a <= (cnt[1:0] < last) ? 32'(next_a) : '0;
            cnt   <= cnt + 3'd1;
          end
        end

        WR: begin
          if (drv) begin
            if (cnt[1:0] == last) begin
              state            <= IDLE;
              cnt              <= '0;
              drv              <= 1'b0;
              mem_a            <= '0;
              mem_dout         <= '0;
              mem_wr           <= 1'b0;
              resp_done[owner] <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= 32'(next_a);
              mem_dout <= wbuf[{next_idx, 3'b000} +: 8];
              mem_wr   <= !next_stall;
              drv      <= !next_stall;
            end
          end else begin
            mem_wr <= !cur_stall;
            drv    <= !cur_stall;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
